// File: rtl/cordic_pkg.sv
// Shared CORDIC constants (Q16.16) and FSM state type, common to the
// vectoring atan2 unit and the rotation-mode sin/cos unit.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SCALE,
        DONE
    } state_e;

    localparam logic signed [31:0] PI     = 32'sh0003_243F;
    localparam logic signed [31:0] TWO_PI = 32'sh0006_487F;
    localparam logic        [31:0] K_INV  = 32'h0000_9B75;

    // atan(2^-i) in Q16.16
    function automatic logic [31:0] atan_lut(input logic [3:0] idx);
        logic [31:0] val;
        case (idx)
            4'd0:    val = 32'h0000_C910;
            4'd1:    val = 32'h0000_76B2;
            4'd2:    val = 32'h0000_3EB7;
            4'd3:    val = 32'h0000_1FD6;
            4'd4:    val = 32'h0000_0FFB;
            4'd5:    val = 32'h0000_07FF;
            4'd6:    val = 32'h0000_0400;
            4'd7:    val = 32'h0000_0200;
            4'd8:    val = 32'h0000_0100;
            4'd9:    val = 32'h0000_0080;
            4'd10:   val = 32'h0000_0040;
            4'd11:   val = 32'h0000_0020;
            4'd12:   val = 32'h0000_0010;
            4'd13:   val = 32'h0000_0008;
            4'd14:   val = 32'h0000_0004;
            default: val = 32'h0000_0002;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode micro-rotation: drives y toward zero and accumulates
// the rotated angle into z.
module cordic_vec_stage #(
    parameter int IW = 34
) (
    input  logic signed [IW-1:0] x_in,
    input  logic signed [IW-1:0] y_in,
    input  logic signed [IW-1:0] z_in,
    input  logic        [3:0]    shift,
    input  logic signed [IW-1:0] atan_i,
    output logic signed [IW-1:0] x_out,
    output logic signed [IW-1:0] y_out,
    output logic signed [IW-1:0] z_out
);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;

    always_comb begin
        x_sh = x_in >>> shift;
        y_sh = y_in >>> shift;
        if (!y_in[IW-1]) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan_i;
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan_i;
        end
    end

endmodule

// File: rtl/cordic_atan2.sv
// Iterative vectoring CORDIC: atan2(y, x) and gain-corrected magnitude of a
// Q16.16 vector, one micro-rotation per clock behind a valid/ready handshake.
module cordic_atan2
    import cordic_pkg::*;
#(
    parameter int NITER = 16,
    parameter int IW    = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_angle,
    output logic [31:0] out_mag,
    output logic        out_zero
);

    localparam int MW = IW + 18;
    localparam logic        [3:0]    LAST_ITER = 4'(NITER - 1);
    localparam logic signed [IW-1:0] PI_W      = {{(IW-32){1'b0}}, PI};
    localparam logic signed [MW-1:0] K_INV_W   = {{(MW-32){1'b0}}, K_INV};
    localparam logic signed [MW-1:0] ROUND_W   = {{(MW-16){1'b0}}, 16'h8000};
    localparam logic signed [MW-1:0] MAG_MAX_W = {{(MW-32){1'b0}}, 32'h7FFF_FFFF};

    state_e               state_q, state_d;
    logic signed [IW-1:0] x_q, x_d;
    logic signed [IW-1:0] y_q, y_d;
    logic signed [IW-1:0] z_q, z_d;
    logic        [3:0]    iter_q, iter_d;
    logic                 out_valid_q, out_valid_d;
    logic        [31:0]   out_angle_q, out_angle_d;
    logic        [31:0]   out_mag_q, out_mag_d;
    logic                 out_zero_q, out_zero_d;

    logic signed [IW-1:0] x_ext, y_ext;
    logic signed [IW-1:0] x_nxt, y_nxt, z_nxt;
    logic signed [IW-1:0] atan_i;
    logic signed [MW-1:0] x_wide, prod, mag_full;
    logic signed [31:0]   z_lo, angle_wrap;
    logic        [31:0]   mag_sat;

    // Guard bits let -2^31 be negated during the quadrant fold.
    assign x_ext  = {{(IW-32){in_x[31]}}, in_x};
    assign y_ext  = {{(IW-32){in_y[31]}}, in_y};
    assign atan_i = {{(IW-32){1'b0}}, atan_lut(iter_q)};

    cordic_vec_stage #(
        .IW(IW)
    ) u_stage (
        .x_in  (x_q),
        .y_in  (y_q),
        .z_in  (z_q),
        .shift (iter_q),
        .atan_i(atan_i),
        .x_out (x_nxt),
        .y_out (y_nxt),
        .z_out (z_nxt)
    );

    always_comb begin
        x_wide   = {{(MW-IW){x_q[IW-1]}}, x_q};
        prod     = x_wide * K_INV_W;
        mag_full = (prod + ROUND_W) >>> 16;
        if (mag_full[MW-1]) begin
            mag_sat = 32'h0;
        end else if (mag_full > MAG_MAX_W) begin
            mag_sat = 32'h7FFF_FFFF;
        end else begin
            mag_sat = mag_full[31:0];
        end

        // |z| < 5 rad, so the low 32 bits carry the whole angle
        z_lo = z_q[31:0];
        if (z_lo > PI) begin
            angle_wrap = z_lo - TWO_PI;
        end else if (z_lo <= -PI) begin
            angle_wrap = z_lo + TWO_PI;
        end else begin
            angle_wrap = z_lo;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        out_valid_d = out_valid_q;
        out_angle_d = out_angle_q;
        out_mag_d   = out_mag_q;
        out_zero_d  = out_zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_x[31]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = in_y[31] ? -PI_W : PI_W;
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                    out_zero_d = (in_x == 32'h0) && (in_y == 32'h0);
                    iter_d     = 4'd0;
                    state_d    = ITER;
                end
            end
            ITER: begin
                x_d    = x_nxt;
                y_d    = y_nxt;
                z_d    = z_nxt;
                iter_d = iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                out_angle_d = out_zero_q ? 32'h0 : angle_wrap;
                out_mag_d   = out_zero_q ? 32'h0 : mag_sat;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= 4'd0;
            out_valid_q <= 1'b0;
            out_angle_q <= 32'h0;
            out_mag_q   <= 32'h0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            out_valid_q <= out_valid_d;
            out_angle_q <= out_angle_d;
            out_mag_q   <= out_mag_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_angle = out_angle_q;
    assign out_mag   = out_mag_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_cordic_atan2.sv
// Directed and random checks of cordic_atan2 against a real-number
// atan2/hypot reference model.
module tb_cordic_atan2;

    localparam int    LAT      = 18;           // edges counted including the accepting edge
    localparam real   PI_R     = 3.14159265358979323846;
    localparam int    PI_Q     = 205887;
    localparam int    TWO_PI_Q = 411775;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_angle;
    logic [31:0] out_mag;
    logic        out_zero;

    int n_pass  = 0;
    int n_total = 0;

    cordic_atan2 #(.NITER(16), .IW(34)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_angle(out_angle),
        .out_mag  (out_mag),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic chk_ang(input string tag, input logic [31:0] got, input int exp);
        int d;
        d = $signed(got) - exp;
        if (d > PI_Q) d -= TWO_PI_Q;
        if (d < -PI_Q) d += TWO_PI_Q;
        n_total++;
        assert ((d <= 8 && d >= -8) === 1'b1) n_pass++;
        else $error("FAIL %s: observed %h expected %h +-8", tag, got, exp);
    endtask

    task automatic chk_near(input string tag, input logic [31:0] got, input int exp);
        int d;
        d = $signed(got) - exp;
        n_total++;
        assert ((d <= 8 && d >= -8) === 1'b1) n_pass++;
        else $error("FAIL %s: observed %h expected %h +-8", tag, got, exp);
    endtask

    task automatic chk_model(input string tag, input logic [31:0] x, input logic [31:0] y);
        real xr, yr, ea, em, d, tol;
        xr = $itor($signed(x));
        yr = $itor($signed(y));
        ea = $atan2(yr, xr) * 65536.0;
        em = $sqrt(xr * xr + yr * yr);
        if (em > 2147483647.0) em = 2147483647.0;
        d = $itor($signed(out_angle)) - ea;
        if (d > PI_R * 65536.0) d -= 2.0 * PI_R * 65536.0;
        if (d < -PI_R * 65536.0) d += 2.0 * PI_R * 65536.0;
        n_total++;
        assert ((d <= 8.0 && d >= -8.0) === 1'b1) n_pass++;
        else $error("FAIL %s angle: x=%h y=%h observed %h expected %f", tag, x, y, out_angle, ea);
        tol = (em / 4096.0 > 8.0) ? em / 4096.0 : 8.0;
        d = $itor($signed(out_mag)) - em;
        n_total++;
        assert ((d <= tol && d >= -tol) === 1'b1) n_pass++;
        else $error("FAIL %s mag: x=%h y=%h observed %h expected %f", tag, x, y, out_mag, em);
    endtask

    // Present a vector, wait for acceptance and then for out_valid (bounded).
    task automatic send(input logic [31:0] x, input logic [31:0] y, output int lat);
        int guard;
        @(negedge clk);
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] a_hold, m_hold;
        logic        stable, seen;
        logic [31:0] rx, ry;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_x = 32'h0;
        in_y = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", {31'b0, in_ready}, 32'h1);
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset out_angle", out_angle, 32'h0);
        chk("reset out_mag", out_mag, 32'h0);
        chk("reset out_zero", {31'b0, out_zero}, 32'h0);

        send(32'h0001_0000, 32'h0, lat);
        chk("latency (1,0)", lat, LAT);
        chk_ang("angle (1,0)", out_angle, 0);
        chk_near("mag (1,0)", out_mag, 32'h0001_0000);
        chk("zero (1,0)", {31'b0, out_zero}, 32'h0);
        chk("in_ready busy", {31'b0, in_ready}, 32'h0);
        consume();
        chk("out_valid drop", {31'b0, out_valid}, 32'h0);
        chk("in_ready after accept", {31'b0, in_ready}, 32'h1);

        send(32'h0, 32'h0001_0000, lat);
        chk_ang("angle (0,1)", out_angle, 32'h0001_921F);
        consume();
        send(32'h0, 32'hFFFF_0000, lat);
        chk_ang("angle (0,-1)", out_angle, 32'hFFFE_6DE1);
        consume();

        send(32'hFFFF_0000, 32'h0, lat);
        chk_ang("angle (-1,0)", out_angle, 32'h0003_243F);
        chk("angle (-1,0) sign", {31'b0, out_angle[31]}, 32'h0);
        consume();
        send(32'hFFFF_0000, 32'hFFFF_FFFF, lat);
        chk_ang("angle (-1,-eps)", out_angle, 32'hFFFC_DBC1);
        consume();

        send(32'h0003_0000, 32'h0004_0000, lat);
        chk_near("mag (3,4)", out_mag, 32'h0005_0000);
        chk_ang("angle (3,4)", out_angle, 32'h0000_ED63);
        a_hold = out_angle;
        m_hold = out_mag;
        in_x = 32'h0007_0000;
        in_y = 32'h0001_0000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stable = out_valid && (out_angle === a_hold) && (out_mag === m_hold) && !in_ready;
            chk("hold stable", {31'b0, stable}, 32'h1);
        end
        in_valid = 1'b0;
        consume();
        chk("in_ready after hold", {31'b0, in_ready}, 32'h1);

        send(32'h0, 32'h0, lat);
        chk("zero flag", {31'b0, out_zero}, 32'h1);
        chk("zero angle", out_angle, 32'h0);
        chk("zero mag", out_mag, 32'h0);
        consume();

        send(32'h8000_0000, 32'h8000_0000, lat);
        chk_model("full-scale", 32'h8000_0000, 32'h8000_0000);
        chk("full-scale mag sat", out_mag, 32'h7FFF_FFFF);
        consume();

        for (int n = 0; n < 1000; n++) begin
            rx = $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
            ry = $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
            if ($signed(rx) < 65536 && $signed(rx) > -65536 &&
                $signed(ry) < 65536 && $signed(ry) > -65536) rx = 32'h0001_0000;
            send(rx, ry, lat);
            chk("random latency", lat, LAT);
            chk_model("random", rx, ry);
            consume();
        end

        @(negedge clk);
        in_x = 32'h0001_0000;
        in_y = 32'h0001_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", {31'b0, in_ready}, 32'h1);
        chk("abort out_valid", {31'b0, out_valid}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("abort no output", {31'b0, seen}, 32'h0);

        send(32'hFFFD_0000, 32'h0002_8000, lat);
        chk("post-abort latency", lat, LAT);
        chk_model("post-abort", 32'hFFFD_0000, 32'h0002_8000);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
